// File: rtl/fc_mac_array.sv
// fc_mac_array
//   Multi-lane fully-connected MAC engine. KPF output lanes each multiply CPF
//   input channels per beat and sum them into a per-lane accumulator across a
//   multi-beat vector. The lane bias is added on the last beat. The final sum
//   is requantized with round-half-up, saturation and optional ReLU, and the
//   result is pushed into a 2-entry output FIFO with ready/valid backpressure.
//
// Ports
//   clk            clock
//   rst            asynchronous reset, active-low
//   op_din_en      input beat valid
//   op_din_eop     last beat of the current vector
//   op_din_rdy     engine can accept a beat (credit based)
//   op_din         CPF channels, channel c at [c*DIN_DW +: DIN_DW]
//   op_weight      lane k, channel c at [(k*CPF+c)*WW +: WW]
//   op_bias        lane k at [k*BIAS_DW +: BIAS_DW], sampled on the eop beat
//   blob_dout_rdy  downstream accepts a word
//   blob_dout_en   output word valid (FIFO head)
//   blob_dout_eop  head word is the last word of the frame
//   blob_dout      lane k at [k*DOUT_DW +: DOUT_DW]
module fc_mac_array #(
  parameter int CPF           = 4,
  parameter int KPF           = 2,
  parameter int DIN_DW        = 8,
  parameter int WW            = 8,
  parameter int BIAS_DW       = 8,
  parameter int BIAS_SHIFT    = 6,
  parameter int ACC_WIDTH     = 24,
  parameter int SHIFT         = 6,
  parameter int DOUT_DW       = 8,
  parameter int RELU          = 0,
  parameter int OUT_PER_FRAME = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      op_din_en,
  input  logic                      op_din_eop,
  output logic                      op_din_rdy,
  input  logic [CPF*DIN_DW-1:0]     op_din,
  input  logic [KPF*CPF*WW-1:0]     op_weight,
  input  logic [KPF*BIAS_DW-1:0]    op_bias,
  input  logic                      blob_dout_rdy,
  output logic                      blob_dout_en,
  output logic                      blob_dout_eop,
  output logic [KPF*DOUT_DW-1:0]    blob_dout
);

  localparam int PW = DIN_DW + WW;
  localparam int FW = (OUT_PER_FRAME > 1) ? $clog2(OUT_PER_FRAME) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(OUT_PER_FRAME - 1);
  localparam logic signed [ACC_WIDTH:0] RND =
    (SHIFT > 0) ? ((ACC_WIDTH+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [ACC_WIDTH:0] OMAX = (ACC_WIDTH+1)'((1 << (DOUT_DW-1)) - 1);
  localparam logic signed [ACC_WIDTH:0] OMIN = ~OMAX;

  logic beat_acc;

  // first_q marks that the next accepted beat opens a new vector
  logic first_q;

  logic                      s1_vld_q, s1_eop_q, s1_first_q;
  logic signed [PW-1:0]      prod_q [KPF][CPF];
  logic signed [PW-1:0]      prod_d [KPF][CPF];
  logic signed [BIAS_DW-1:0] bias_q [KPF];

  logic                        s2_vld_q;
  logic signed [ACC_WIDTH-1:0] acc_q [KPF];
  logic signed [ACC_WIDTH-1:0] acc_d [KPF];

  logic signed [ACC_WIDTH:0]   rsum [KPF];
  logic signed [ACC_WIDTH:0]   rsh  [KPF];
  logic [KPF*DOUT_DW-1:0]      wdata_d;

  logic [KPF*DOUT_DW-1:0] mem_q [2];
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             occ_q;
  logic [FW-1:0]          frame_q;
  logic                   push, pop;
  logic [2:0]             credit;

  // Every eop already accepted is guaranteed a FIFO slot, so the pipeline
  // never has to stall behind the output buffer.
  assign credit     = {1'b0, occ_q} + {2'b00, s1_vld_q & s1_eop_q} + {2'b00, s2_vld_q};
  assign op_din_rdy = (credit < 3'd2);
  assign beat_acc   = op_din_en & op_din_rdy;

  // ---------------- stage 1: products ----------------
  always_comb begin
    for (int k = 0; k < KPF; k++) begin
      for (int c = 0; c < CPF; c++) begin
        prod_d[k][c] = PW'($signed(op_din[c*DIN_DW +: DIN_DW])) *
                       PW'($signed(op_weight[(k*CPF+c)*WW +: WW]));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_q    <= 1'b1;
      s1_vld_q   <= 1'b0;
      s1_eop_q   <= 1'b0;
      s1_first_q <= 1'b0;
      for (int k = 0; k < KPF; k++) begin
        bias_q[k] <= '0;
        for (int c = 0; c < CPF; c++) prod_q[k][c] <= '0;
      end
    end else begin
      s1_vld_q <= beat_acc;
      if (beat_acc) begin
        first_q    <= op_din_eop;
        s1_eop_q   <= op_din_eop;
        s1_first_q <= first_q;
        for (int k = 0; k < KPF; k++) begin
          for (int c = 0; c < CPF; c++) prod_q[k][c] <= prod_d[k][c];
          if (op_din_eop) bias_q[k] <= $signed(op_bias[k*BIAS_DW +: BIAS_DW]);
        end
      end
    end
  end

  // ---------------- stage 2: accumulate ----------------
  always_comb begin
    for (int k = 0; k < KPF; k++) begin
      acc_d[k] = s1_first_q ? '0 : acc_q[k];
      for (int c = 0; c < CPF; c++) acc_d[k] = acc_d[k] + ACC_WIDTH'(prod_q[k][c]);
      if (s1_eop_q) acc_d[k] = acc_d[k] + (ACC_WIDTH'(bias_q[k]) <<< BIAS_SHIFT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld_q <= 1'b0;
      for (int k = 0; k < KPF; k++) acc_q[k] <= '0;
    end else begin
      s2_vld_q <= s1_vld_q & s1_eop_q;
      if (s1_vld_q) begin
        for (int k = 0; k < KPF; k++) acc_q[k] <= acc_d[k];
      end
    end
  end

  // ---------------- stage 3: requantize into the FIFO ----------------
  // One extra bit keeps the rounding add from wrapping near full scale.
  always_comb begin
    wdata_d = '0;
    for (int k = 0; k < KPF; k++) begin
      rsum[k] = (ACC_WIDTH+1)'(acc_q[k]) + RND;
      rsh[k]  = rsum[k] >>> SHIFT;
      if (rsh[k] > OMAX)      wdata_d[k*DOUT_DW +: DOUT_DW] = OMAX[DOUT_DW-1:0];
      else if (rsh[k] < OMIN) wdata_d[k*DOUT_DW +: DOUT_DW] = OMIN[DOUT_DW-1:0];
      else                    wdata_d[k*DOUT_DW +: DOUT_DW] = rsh[k][DOUT_DW-1:0];
      if ((RELU != 0) && wdata_d[k*DOUT_DW + DOUT_DW - 1])
        wdata_d[k*DOUT_DW +: DOUT_DW] = '0;
    end
  end

  assign push          = s2_vld_q;
  assign pop           = blob_dout_en & blob_dout_rdy;
  assign blob_dout_en  = (occ_q != 2'd0);
  assign blob_dout     = mem_q[rd_ptr_q];
  assign blob_dout_eop = blob_dout_en & (frame_q == FRAME_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      frame_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata_d;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        frame_q  <= (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_mac_array.sv
module tb_fc_mac_array;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_din_en = 1'b0, op_din_eop = 1'b0;
  logic [31:0] op_din = '0;
  logic [63:0] op_weight = '0;
  logic [15:0] op_bias = '0;
  logic        blob_dout_rdy = 1'b1;
  logic        rdy, en, eop, rdy_r, en_r, eop_r;
  logic [15:0] dout, dout_r;

  int n_pass = 0;
  int n_total = 0;
  int fidx = 0;

  always #5 clk = ~clk;

  fc_mac_array dut (
    .clk(clk), .rst(rst), .op_din_en(op_din_en), .op_din_eop(op_din_eop),
    .op_din_rdy(rdy), .op_din(op_din), .op_weight(op_weight), .op_bias(op_bias),
    .blob_dout_rdy(blob_dout_rdy), .blob_dout_en(en), .blob_dout_eop(eop),
    .blob_dout(dout));

  fc_mac_array #(.RELU(1)) dut_r (
    .clk(clk), .rst(rst), .op_din_en(op_din_en), .op_din_eop(op_din_eop),
    .op_din_rdy(rdy_r), .op_din(op_din), .op_weight(op_weight), .op_bias(op_bias),
    .blob_dout_rdy(blob_dout_rdy), .blob_dout_en(en_r), .blob_dout_eop(eop_r),
    .blob_dout(dout_r));

  typedef struct {
    logic [31:0] din;
    logic [63:0] wt;
    logic [15:0] bias;
    logic [15:0] exp;
    logic [15:0] exp_r;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Drive one beat and hold it until the engine accepts it; returns #1 after
  // the accepting edge.
  task automatic send(input logic [31:0] d, input logic [63:0] w,
                      input logic [15:0] b, input logic e);
    int n;
    @(negedge clk);
    op_din = d; op_weight = w; op_bias = b; op_din_eop = e; op_din_en = 1'b1;
    n = 0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      chk("send_rdy_timeout", {31'b0, rdy}, 32'd1);
      op_din_en = 1'b0; op_din_eop = 1'b0;
    end else begin
      @(posedge clk); #1;
      op_din_en = 1'b0; op_din_eop = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] words [3];
    int          got;
    logic        acc;

    //            din            weights {lane1,lane0}    bias      exp       exp relu
    tbl[0] = '{32'h10101010, 64'hF0F0F0F0_10101010, 16'h0000, 16'hF010, 16'h0010};
    tbl[1] = '{32'h7F7F7F7F, 64'h81818181_7F7F7F7F, 16'h0000, 16'h807F, 16'h007F};
    tbl[2] = '{32'h08080808, 64'hFFFFFFFF_01010101, 16'h0000, 16'h0001, 16'h0001};
    tbl[3] = '{32'h07080808, 64'h02020202_01010101, 16'h0000, 16'h0100, 16'h0100};
    tbl[4] = '{32'h00000000, 64'h00000000_00000000, 16'h05FF, 16'h05FF, 16'h0500};
    tbl[5] = '{32'h000000DF, 64'hFFFFFFFF_01010101, 16'h0000, 16'h01FF, 16'h0100};
    tbl[6] = '{32'h80808080, 64'h00000000_80808080, 16'h7F00, 16'h7F7F, 16'h7F7F};

    // reset state
    #12;
    chk("rst_en", en, 0);
    chk("rst_eop", eop, 0);
    chk("rst_dout", dout, 0);
    chk("rst_en_relu", en_r, 0);
    chk("rst_eop_relu", eop_r, 0);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rst_rdy", rdy, 1);
    chk("rst_rdy_relu", rdy_r, 1);

    // single-beat vectors: latency, arithmetic, saturation, rounding, relu
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].din, tbl[i].wt, tbl[i].bias, 1'b1);
      chk($sformatf("v%0d_en_c0", i), en, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_en_c1", i), en, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_en_c2", i), en, 1);
      chk($sformatf("v%0d_dout", i), dout, tbl[i].exp);
      chk($sformatf("v%0d_dout_relu", i), dout_r, tbl[i].exp_r);
    end
    @(posedge clk); #1;
    chk("table_drain", en, 0);

    // two-beat vector with an idle stall between beats; bias on the eop beat
    send(tbl[0].din, tbl[0].wt, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_vec_no_out", en, 0);
    send(32'h0, tbl[0].wt, 16'h0001, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("two_beat_en", en, 1);
    chk("two_beat_dout", dout, 16'hF011);
    chk("two_beat_dout_relu", dout_r, 16'h0011);
    @(posedge clk); #1;

    // backpressure: two words fill the credits, third beat is held
    @(negedge clk); blob_dout_rdy = 1'b0;
    send(tbl[2].din, tbl[2].wt, tbl[2].bias, 1'b1);
    chk("bp_rdy_after1", rdy, 1);
    send(tbl[4].din, tbl[4].wt, tbl[4].bias, 1'b1);
    chk("bp_rdy_after2", rdy, 0);
    @(negedge clk);
    op_din = tbl[0].din; op_weight = tbl[0].wt; op_bias = tbl[0].bias;
    op_din_eop = 1'b1; op_din_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_rdy_held", rdy, 0);
    chk("bp_en_held", en, 1);
    chk("bp_dout_held", dout, tbl[2].exp);
    @(posedge clk); #1;
    chk("bp_dout_stable", dout, tbl[2].exp);
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      @(negedge clk);
      blob_dout_rdy = 1'b1;
      if (en) begin
        words[got] = dout;
        got++;
      end
      acc = op_din_en & rdy;
      @(posedge clk); #1;
      if (acc) begin op_din_en = 1'b0; op_din_eop = 1'b0; end
    end
    op_din_en = 1'b0; op_din_eop = 1'b0;
    chk("bp_word_count", got, 3);
    chk("bp_word0", words[0], tbl[2].exp);
    chk("bp_word1", words[1], tbl[4].exp);
    chk("bp_word2", words[2], tbl[0].exp);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_dup", en, 0);

    // frame eop: fresh frame counter, 33 words
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    fidx = 0;
    fork
      begin
        for (int i = 0; i < 33; i++) send(tbl[2].din, tbl[2].wt, tbl[2].bias, 1'b1);
      end
      begin
        for (int cyc = 0; cyc < 400 && fidx < 33; cyc++) begin
          @(negedge clk);
          if (en && blob_dout_rdy) begin
            chk($sformatf("frame_eop_w%0d", fidx), eop, (fidx == 31));
            fidx++;
          end
        end
      end
    join
    chk("frame_word_count", fidx, 33);

    // reset mid-vector with a word pending in the buffer
    @(negedge clk); blob_dout_rdy = 1'b0;
    send(tbl[0].din, tbl[0].wt, tbl[0].bias, 1'b1);
    send(tbl[1].din, tbl[1].wt, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_en", en, 1);
    chk("pre_rst_dout", dout, tbl[0].exp);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_en", en, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_eop", eop, 0);
    chk("mid_rst_rdy", rdy, 1);
    @(negedge clk); rst = 1'b1; blob_dout_rdy = 1'b1;
    send(tbl[2].din, tbl[2].wt, tbl[2].bias, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("post_rst_en", en, 1);
    chk("post_rst_dout", dout, tbl[2].exp);
    chk("post_rst_eop", eop, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
